// File: rtl/key_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : key_ctrl
//  Purpose  : Front-panel key conditioner for the 0-59 seconds counter.
//             Two raw active-low push buttons (pause/run and clear) are
//             synchronised and debounced independently. The pause key
//             toggles the run enable, and the clear key holds the
//             active-low clear for as long as it is debounced-down.
//  Ports    : cp          - system clock (50 MHz board clock)
//             cr          - synchronous active-high reset
//             key_pause_n - raw pause/run button, asynchronous, low = pressed
//             key_clr_n   - raw clear button, asynchronous, low = pressed
//             ce          - run enable to counter (1 = counting)
//             clr_n       - active-low clear to counter (low while held)
//             pause_p     - one-cycle pulse per accepted pause press
//             clr_p       - one-cycle pulse per accepted clear press
//  Revision : 1.0 - initial release
// ============================================================================
module key_ctrl #(
    parameter int DB_CNT = 1000000  // stable cycles needed to accept a level change (>= 2)
) (
    input  logic cp,
    input  logic cr,
    input  logic key_pause_n,
    input  logic key_clr_n,
    output logic ce,
    output logic clr_n,
    output logic pause_p,
    output logic clr_p
);

    // Counter width; the guard keeps the width legal if DB_CNT is misset to 1.
    localparam int CW = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;
    localparam logic [CW-1:0] c_cnt_max = CW'(DB_CNT - 1);
    localparam int c_nkeys = 2;

    // Index of each key in the per-key vectors below.
    localparam int c_key_pause = 0;
    localparam int c_key_clr   = 1;

    // Encoding is chosen so that bit 1 alone marks the "held" states
    // (DOWN and RWAIT). The clear output is then a straight flop bit and
    // cannot glitch while the state register changes.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PWAIT = 2'b01,
        ST_DOWN  = 2'b10,
        ST_RWAIT = 2'b11
    } state_t;

    logic [c_nkeys-1:0] w_key_raw;
    logic [c_nkeys-1:0] w_press_d;   // press accepted on the coming edge
    logic [c_nkeys-1:0] pulse_q;
    logic               ce_q;

    assign w_key_raw = {key_clr_n, key_pause_n};

    // ------------------------------------------------------------------------
    // Per-key synchroniser + debouncer
    // ------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < c_nkeys; gi++) begin : g_key
            logic          sync1_q;
            logic          ks_q;
            state_t        state_q;
            logic [CW-1:0] cnt_q;

            // The press is taken when PWAIT has seen DB_CNT consecutive low
            // samples; the counter value at that moment is DB_CNT-1.
            assign w_press_d[gi] = (state_q == ST_PWAIT) && !ks_q &&
                                   (cnt_q == c_cnt_max);

            always_ff @(posedge cp) begin
                if (cr) begin
                    sync1_q <= 1'b1;
                    ks_q    <= 1'b1;
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end else begin
                    sync1_q <= w_key_raw[gi];
                    ks_q    <= sync1_q;
                    case (state_q)
                        ST_IDLE: begin
                            cnt_q <= '0;
                            if (!ks_q) begin
                                state_q <= ST_PWAIT;
                            end
                        end
                        ST_PWAIT: begin
                            if (ks_q) begin
                                // Bounce: drop the partial count.
                                state_q <= ST_IDLE;
                                cnt_q   <= '0;
                            end else if (cnt_q == c_cnt_max) begin
                                state_q <= ST_DOWN;
                                cnt_q   <= '0;
                            end else begin
                                cnt_q <= cnt_q + CW'(1);
                            end
                        end
                        ST_DOWN: begin
                            cnt_q <= '0;
                            if (ks_q) begin
                                state_q <= ST_RWAIT;
                            end
                        end
                        ST_RWAIT: begin
                            if (!ks_q) begin
                                // Short high glitch while held: resume the
                                // hold without a new press.
                                state_q <= ST_DOWN;
                                cnt_q   <= '0;
                            end else if (cnt_q == c_cnt_max) begin
                                state_q <= ST_IDLE;
                                cnt_q   <= '0;
                            end else begin
                                cnt_q <= cnt_q + CW'(1);
                            end
                        end
                        default: begin
                            state_q <= ST_IDLE;
                            cnt_q   <= '0;
                        end
                    endcase
                end
            end

            // Only the clear key exposes its held level.
            if (gi == c_key_clr) begin : g_held
                assign clr_n = ~state_q[1];
            end
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Output registers: press pulses and the run-enable toggle. ce flips on
    // the same edge that raises pause_p.
    // ------------------------------------------------------------------------
    always_ff @(posedge cp) begin
        if (cr) begin
            pulse_q <= '0;
            ce_q    <= 1'b0;
        end else begin
            pulse_q <= w_press_d;
            if (w_press_d[c_key_pause]) begin
                ce_q <= ~ce_q;
            end
        end
    end

    assign ce      = ce_q;
    assign pause_p = pulse_q[c_key_pause];
    assign clr_p   = pulse_q[c_key_clr];

endmodule
`default_nettype wire
